// File: rtl/ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, execute-stage
// redirect and the decoder-facing instruction handshake.
interface ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Fetch-unit side
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    // Environment side: memory, execute stage and decoder
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, single-outstanding fetch FSM and a
// small {pc, inst} FIFO feeding the decoder. A redirect flushes the FIFO and
// restarts fetch; a response already in flight is dropped via StDrop.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic   clk,
    input logic   rst_n,
    ifu_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [PtrW:0]   cnt_t;
    localparam cnt_t Full = cnt_t'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];

    logic        pop;
    logic        push;
    cnt_t        post_pop;
    logic [31:0] redirect_target;

    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst           = bus.inst_valid ? fifo_inst[rd_ptr_q] : '0;
    assign bus.inst_pc        = bus.inst_valid ? fifo_pc[rd_ptr_q] : '0;
    assign bus.imem_req_valid = (state_q == StReq);
    assign bus.imem_req_addr  = pc_q;

    assign pop             = bus.inst_valid & bus.inst_ready;
    assign post_pop        = count_q - cnt_t'(pop);
    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    // Fetch FSM next state; push only for a live response not hit by a redirect
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.redirect_valid || (post_pop < Full)) state_d = StReq;
            end
            StReq: begin
                if (bus.imem_req_ready) state_d = bus.redirect_valid ? StDrop : StWait;
            end
            StWait: begin
                if (bus.imem_resp_valid) begin
                    if (bus.redirect_valid) begin
                        state_d = StReq;
                    end else begin
                        push    = 1'b1;
                        state_d = ((post_pop + cnt_t'(1)) < Full) ? StReq : StIdle;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (bus.imem_resp_valid) state_d = StReq;
            end
            default: state_d = StIdle;
        endcase
    end

    // PC and FIFO bookkeeping; a redirect clears everything, even a same-cycle pop
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            pc_d     = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
            count_d = post_pop + cnt_t'(push);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only visible through inst_valid gating
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr_q]   <= pc_q;
            fifo_inst[wr_ptr_q] <= bus.imem_resp_data;
        end
    end
endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a latency-configurable memory model, a
// scoreboard of expected {pc, inst} pairs and directed scenario tasks.
module tb_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ifu_if bus ();

    ifu #(
        .RESET_PC(RESET_PC),
        .DEPTH   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    entry_t      exp_q[$];
    entry_t      mon_e;
    int          checks   = 0;
    int          errors   = 0;
    int          pops     = 0;
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    bit          live     = 1'b0;
    logic [31:0] exp_pc   = RESET_PC;

    // Memory model and scoreboard, evaluated mid-cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            live                = 1'b0;
            mem_busy            = 1'b0;
            exp_pc              = RESET_PC;
            bus.imem_resp_valid = 1'b0;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_busy            = 1'b0;
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_addr ^ KEY;
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got pc %h inst %h want no output",
                             bus.inst_pc, bus.inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.inst_pc !== mon_e.pc || bus.inst !== mon_e.data) begin
                        errors++;
                        $display("FAIL pop_order got pc %h inst %h want pc %h inst %h",
                                 bus.inst_pc, bus.inst, mon_e.pc, mon_e.data);
                    end
                end
            end
            if (bus.imem_resp_valid && live && !bus.redirect_valid) begin
                exp_q.push_back({exp_pc, exp_pc ^ KEY});
                exp_pc = exp_pc + 32'd4;
                live   = 1'b0;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                checks++;
                if (bus.imem_req_addr !== exp_pc || mem_busy) begin
                    errors++;
                    $display("FAIL req_addr got %h busy %0b want %h busy 0",
                             bus.imem_req_addr, mem_busy, exp_pc);
                end
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = bus.imem_req_addr;
                live     = !bus.redirect_valid;
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                live   = 1'b0;
                exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one tick after the first edge with rst_n high (i.e. in cycle 1)
    task automatic do_reset();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC ||
            bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin
            errors++;
            $display("FAIL %s got req_valid %b addr %h inst_valid %b inst %h inst_pc %h want 0 %h 0 0 0",
                     tag, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid,
                     bus.inst, bus.inst_pc, RESET_PC);
        end
    endtask

    task automatic test_reset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        mem_lat            = 1;
        step(2);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        step(1);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req got valid %b addr %h want 1 %h",
                     bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_straight_fetch();
        int p0;
        step(1);
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL inst_early got %b want 0", bus.inst_valid);
        end
        step(1);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC || bus.inst !== (RESET_PC ^ KEY)) begin
            errors++;
            $display("FAIL first_inst got valid %b pc %h inst %h want 1 %h %h",
                     bus.inst_valid, bus.inst_pc, bus.inst, RESET_PC, RESET_PC ^ KEY);
        end
        step(1);
        p0 = pops;
        step(10);
        checks++;
        if (pops - p0 != 5) begin
            errors++;
            $display("FAIL throughput got %0d pops want 5", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        bus.inst_ready = 1'b0;
        mem_lat        = 1;
        do_reset();
        step(8);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b1 ||
            bus.inst_pc !== RESET_PC || bus.inst !== (RESET_PC ^ KEY)) begin
            errors++;
            $display("FAIL bp_idle got req %b valid %b pc %h inst %h want 0 1 %h %h",
                     bus.imem_req_valid, bus.inst_valid, bus.inst_pc, bus.inst,
                     RESET_PC, RESET_PC ^ KEY);
        end
        step(3);
        checks++;
        if (bus.inst_pc !== RESET_PC || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable got pc %h req %b want %h 0",
                     bus.inst_pc, bus.imem_req_valid, RESET_PC);
        end
        bus.inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            found = bus.imem_req_valid;
        end
        checks++;
        if (!found || bus.imem_req_addr !== 32'h8000_0008) begin
            errors++;
            $display("FAIL bp_resume got found %0b addr %h want 1 80000008",
                     found, bus.imem_req_addr);
        end
        step(10);
    endtask

    task automatic test_redirect_wait();
        bit found;
        bus.inst_ready = 1'b1;
        mem_lat        = 3;
        do_reset();
        step(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0103;
        step(1);
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_flush got valid %b req %b want 0 0",
                     bus.inst_valid, bus.imem_req_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1);
            found = bus.imem_req_valid;
        end
        checks++;
        if (!found || bus.imem_req_addr !== 32'h8000_0100 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_restart got found %0b addr %h valid %b want 1 80000100 0",
                     found, bus.imem_req_addr, bus.inst_valid);
        end
        step(14);
    endtask

    task automatic test_redirect_accept();
        bus.inst_ready = 1'b1;
        mem_lat        = 1;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        step(1);
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ra_drop got req %b want 0", bus.imem_req_valid);
        end
        step(1);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0200) begin
            errors++;
            $display("FAIL ra_restart got req %b addr %h want 1 80000200",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        step(2);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8000_0200) begin
            errors++;
            $display("FAIL ra_first got valid %b pc %h want 1 80000200",
                     bus.inst_valid, bus.inst_pc);
        end
        step(8);
    endtask

    task automatic test_push_pop();
        bus.inst_ready = 1'b0;
        mem_lat        = 1;
        do_reset();
        step(3);
        bus.inst_ready = 1'b1;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC) begin
            errors++;
            $display("FAIL pp_head got valid %b pc %h want 1 %h",
                     bus.inst_valid, bus.inst_pc, RESET_PC);
        end
        step(1);
        bus.inst_ready = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8000_0004) begin
            errors++;
            $display("FAIL pp_next got valid %b pc %h want 1 80000004",
                     bus.inst_valid, bus.inst_pc);
        end
        step(3);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_pc !== 32'h8000_0004) begin
            errors++;
            $display("FAIL pp_full got req %b pc %h want 0 80000004",
                     bus.imem_req_valid, bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        step(1);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_000C ||
            bus.inst_pc !== 32'h8000_0008) begin
            errors++;
            $display("FAIL pp_resume got req %b addr %h pc %h want 1 8000000c 80000008",
                     bus.imem_req_valid, bus.imem_req_addr, bus.inst_pc);
        end
        step(8);
    endtask

    task automatic test_wrap_reset();
        bit found;
        bus.inst_ready = 1'b0;
        mem_lat        = 1;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step(1);
        bus.redirect_valid = 1'b0;
        mem_lat            = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1);
            found = mem_busy && (mem_addr == 32'h0);
        end
        checks++;
        if (!found || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap got found %0b valid %b pc %h want 1 1 fffffffc",
                     found, bus.inst_valid, bus.inst_pc);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_wait_reset");
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_straight_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_accept();
        test_push_pop();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
